// File: rtl/trap_ctrl.sv
// Commit-side trap sequencer: latch target/cause, flush, wait for drain, then one fetch redirect.
// Latency: flush/trap_we 1 cycle after the event, redirect valid from 2 cycles; redirect held until redirect_ready.
module trap_ctrl #(
  parameter int ADDR      = 32,
  parameter int DATA      = 32,
  parameter int CODE_W    = 5,
  parameter int DRAIN_MAX = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit_exp_,
  input  logic [CODE_W-1:0] commit_exp_code,
  input  logic              commit_mret,
  input  logic [ADDR-1:0]   commit_pc,
  input  logic [ADDR-1:0]   exp_handler_pc,
  input  logic [ADDR-1:0]   creg_epc,
  input  logic              pipe_empty,
  input  logic              redirect_ready,
  output logic              flush,
  output logic              busy,
  output logic              redirect_valid,
  output logic [ADDR-1:0]   redirect_pc,
  output logic              trap_we,
  output logic [ADDR-1:0]   trap_epc,
  output logic [DATA-1:0]   trap_cause,
  output logic              mret_done,
  output logic              drain_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  localparam int            CW      = $clog2(DRAIN_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DRAIN_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]        state_q, state_d;
  logic [ADDR-1:0]   tgt_q, tgt_d;
  logic [ADDR-1:0]   epc_q, epc_d;
  logic [CODE_W-1:0] cause_q, cause_d;
  logic              kind_mret_q, kind_mret_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              flush_q, flush_d;
  logic              trap_we_q, trap_we_d;
  logic              busy_q, busy_d;
  logic              mret_done_q, mret_done_d;

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    kind_mret_d = kind_mret_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    flush_d     = 1'b0;
    trap_we_d   = 1'b0;
    mret_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Exception has priority; a simultaneous MRET is dropped.
        if (!commit_exp_) begin
          tgt_d       = exp_handler_pc;
          epc_d       = commit_pc;
          cause_d     = commit_exp_code;
          kind_mret_d = 1'b0;
          cnt_d       = '0;
          flush_d     = 1'b1;
          trap_we_d   = 1'b1;
          state_d     = S_DRAIN;
        end else if (commit_mret) begin
          tgt_d       = creg_epc;
          kind_mret_d = 1'b1;
          cnt_d       = '0;
          flush_d     = 1'b1;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
        // Timeout is only a diagnostic; the sequencer keeps waiting for the drain.
        if (cnt_d == CNT_MAX) begin
          timeout_d = 1'b1;
        end
        if (pipe_empty) begin
          state_d = S_REDIR;
        end
      end
      S_REDIR: begin
        if (redirect_ready) begin
          mret_done_d = kind_mret_q;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tgt_q       <= '0;
      epc_q       <= '0;
      cause_q     <= '0;
      kind_mret_q <= 1'b0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      flush_q     <= 1'b0;
      trap_we_q   <= 1'b0;
      busy_q      <= 1'b0;
      mret_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      epc_q       <= epc_d;
      cause_q     <= cause_d;
      kind_mret_q <= kind_mret_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      flush_q     <= flush_d;
      trap_we_q   <= trap_we_d;
      busy_q      <= busy_d;
      mret_done_q <= mret_done_d;
    end
  end

  assign flush          = flush_q;
  assign busy           = busy_q;
  assign redirect_valid = (state_q == S_REDIR);
  assign redirect_pc    = tgt_q;
  assign trap_we        = trap_we_q;
  assign trap_epc       = epc_q;
  assign trap_cause     = DATA'(cause_q);
  assign mret_done      = mret_done_q;
  assign drain_timeout  = timeout_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus random traffic against a timeline-level reference model.
module tb_trap_ctrl;

  localparam int DRAIN_MAX = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        commit_exp_ = 1'b1;
  logic [4:0]  commit_exp_code = '0;
  logic        commit_mret = 1'b0;
  logic [31:0] commit_pc = '0;
  logic [31:0] exp_handler_pc = '0;
  logic [31:0] creg_epc = '0;
  logic        pipe_empty = 1'b1;
  logic        redirect_ready = 1'b1;
  logic        flush, busy, redirect_valid, trap_we, mret_done, drain_timeout;
  logic [31:0] redirect_pc, trap_epc, trap_cause;

  trap_ctrl #(.ADDR(32), .DATA(32), .CODE_W(5), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .reset(reset),
    .commit_exp_(commit_exp_), .commit_exp_code(commit_exp_code), .commit_mret(commit_mret),
    .commit_pc(commit_pc), .exp_handler_pc(exp_handler_pc), .creg_epc(creg_epc),
    .pipe_empty(pipe_empty), .redirect_ready(redirect_ready),
    .flush(flush), .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_we(trap_we), .trap_epc(trap_epc), .trap_cause(trap_cause),
    .mret_done(mret_done), .drain_timeout(drain_timeout)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a trap sequence is a timeline -- accepted, then drain cycles counted
  // until pipe_empty is seen, then a redirect offered until fetch takes it.
  bit          seq = 0, drained = 0, is_mret = 0;
  int          drain_n = 0;
  logic        e_flush = 0, e_we = 0, e_busy = 0, e_valid = 0, e_mret_done = 0, e_to = 0;
  logic [31:0] e_tgt = '0, e_epc = '0;
  logic [4:0]  e_cause = '0;
  logic [31:0] sb_q[$];

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      seq = 0; drained = 0; is_mret = 0; drain_n = 0;
      e_flush = 0; e_we = 0; e_busy = 0; e_valid = 0; e_mret_done = 0; e_to = 0;
      e_tgt = '0; e_epc = '0; e_cause = '0;
      sb_q.delete();
    end else begin
      e_flush = 0; e_we = 0; e_mret_done = 0;
      if (!seq) begin
        if (!commit_exp_) begin
          seq = 1; drained = 0; drain_n = 0; is_mret = 0;
          e_tgt = exp_handler_pc; e_epc = commit_pc; e_cause = commit_exp_code;
          e_flush = 1; e_we = 1;
          sb_q.push_back(exp_handler_pc);
        end else if (commit_mret) begin
          seq = 1; drained = 0; drain_n = 0; is_mret = 1;
          e_tgt = creg_epc; e_flush = 1;
          sb_q.push_back(creg_epc);
        end
      end else if (!drained) begin
        drain_n++;
        if (drain_n >= DRAIN_MAX) e_to = 1;
        if (pipe_empty) drained = 1;
      end else if (redirect_ready) begin
        seq = 0;
        e_mret_done = is_mret;
      end
      e_busy = seq;
      e_valid = seq && drained;
    end
  end

  // Per-cycle compare at the falling edge; inputs only change just after rising edges.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("m_busy", 64'(busy), 64'(e_busy));
      chk("m_flush", 64'(flush), 64'(e_flush));
      chk("m_trap_we", 64'(trap_we), 64'(e_we));
      chk("m_valid", 64'(redirect_valid), 64'(e_valid));
      chk("m_mret_done", 64'(mret_done), 64'(e_mret_done));
      chk("m_timeout", 64'(drain_timeout), 64'(e_to));
      chk("m_epc", 64'(trap_epc), 64'(e_epc));
      chk("m_cause", 64'(trap_cause), 64'(e_cause));
      if (e_valid) chk("m_redirect_pc", 64'(redirect_pc), 64'(e_tgt));
      if (redirect_valid && redirect_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_spurious_hs", 64'(1), 64'(0));
        end else begin
          chk("sb_hs_pc", 64'(redirect_pc), 64'(sb_q.pop_front()));
          hs_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic [4:0] code, input logic [31:0] pc, input logic [31:0] hpc);
    commit_exp_ = 1'b0; commit_exp_code = code; commit_pc = pc; exp_handler_pc = hpc;
  endtask

  int hs0;

  initial begin
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_flush", 64'(flush), 64'(0));
    chk("rst_valid", 64'(redirect_valid), 64'(0));
    chk("rst_trap_we", 64'(trap_we), 64'(0));
    chk("rst_mret_done", 64'(mret_done), 64'(0));
    chk("rst_timeout", 64'(drain_timeout), 64'(0));
    chk("rst_epc", 64'(trap_epc), 64'(0));
    reset = 1'b0;
    chk_en = 1'b1;
    tick();

    // Exception, drain immediate, fetch ready.
    set_exp(5'd2, 32'h100, 32'h8000_0010);
    tick();
    commit_exp_ = 1'b1;
    chk("t1_flush", 64'(flush), 64'(1));
    chk("t1_trap_we", 64'(trap_we), 64'(1));
    chk("t1_epc", 64'(trap_epc), 64'(32'h100));
    chk("t1_cause", 64'(trap_cause), 64'(2));
    chk("t1_busy", 64'(busy), 64'(1));
    tick();
    chk("t1_valid", 64'(redirect_valid), 64'(1));
    chk("t1_rpc", 64'(redirect_pc), 64'(32'h8000_0010));
    chk("t1_flush_off", 64'(flush), 64'(0));
    tick();
    chk("t1_idle", 64'(busy), 64'(0));
    chk("t1_valid_off", 64'(redirect_valid), 64'(0));

    // Fetch back-pressures for 5 cycles.
    hs0 = hs_cnt;
    redirect_ready = 1'b0;
    set_exp(5'd7, 32'h300, 32'h8000_0020);
    tick();
    commit_exp_ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_valid_hold", 64'(redirect_valid), 64'(1));
      chk("t2_rpc_hold", 64'(redirect_pc), 64'(32'h8000_0020));
    end
    redirect_ready = 1'b1;
    tick();
    chk("t2_idle", 64'(busy), 64'(0));
    chk("t2_one_hs", 64'(hs_cnt - hs0), 64'(1));

    // MRET.
    commit_mret = 1'b1; creg_epc = 32'h200;
    tick();
    commit_mret = 1'b0;
    chk("t3_flush", 64'(flush), 64'(1));
    chk("t3_no_we", 64'(trap_we), 64'(0));
    chk("t3_epc_kept", 64'(trap_epc), 64'(32'h300));
    tick();
    chk("t3_rpc", 64'(redirect_pc), 64'(32'h200));
    chk("t3_md_early", 64'(mret_done), 64'(0));
    tick();
    chk("t3_mret_done", 64'(mret_done), 64'(1));
    tick();
    chk("t3_md_pulse", 64'(mret_done), 64'(0));

    // Exception and MRET together: exception wins.
    set_exp(5'd3, 32'h400, 32'h8000_0030);
    commit_mret = 1'b1; creg_epc = 32'h500;
    tick();
    commit_exp_ = 1'b1; commit_mret = 1'b0;
    chk("t4_we", 64'(trap_we), 64'(1));
    chk("t4_cause", 64'(trap_cause), 64'(3));
    tick();
    chk("t4_rpc", 64'(redirect_pc), 64'(32'h8000_0030));
    tick();
    chk("t4_no_md", 64'(mret_done), 64'(0));

    // Second exception while draining is ignored.
    pipe_empty = 1'b0;
    set_exp(5'd4, 32'h600, 32'h8000_0040);
    tick();
    set_exp(5'd9, 32'h700, 32'h9000_0000);
    tick();
    chk("t6_no_flush", 64'(flush), 64'(0));
    chk("t6_no_we", 64'(trap_we), 64'(0));
    chk("t6_epc", 64'(trap_epc), 64'(32'h600));
    chk("t6_cause", 64'(trap_cause), 64'(4));
    commit_exp_ = 1'b1; pipe_empty = 1'b1;
    tick();
    chk("t6_rpc", 64'(redirect_pc), 64'(32'h8000_0040));
    tick();

    // Reset while the redirect is pending.
    redirect_ready = 1'b0;
    set_exp(5'd5, 32'h900, 32'h8000_0050);
    tick();
    commit_exp_ = 1'b1;
    tick();
    chk("t6_redir", 64'(redirect_valid), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(redirect_valid), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_epc", 64'(trap_epc), 64'(0));
    chk("t6_rst_cause", 64'(trap_cause), 64'(0));
    chk("t6_rst_rpc", 64'(redirect_pc), 64'(0));
    tick();
    tick();
    reset = 1'b0;
    redirect_ready = 1'b1;
    tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      commit_exp_     = ($urandom_range(3) != 0);
      commit_mret     = ($urandom_range(3) == 0);
      commit_exp_code = 5'($urandom);
      commit_pc       = $urandom;
      exp_handler_pc  = $urandom;
      creg_epc        = $urandom;
      pipe_empty      = ($urandom_range(1) == 1);
      redirect_ready  = ($urandom_range(1) == 1);
      tick();
    end
    commit_exp_ = 1'b1; commit_mret = 1'b0; pipe_empty = 1'b1; redirect_ready = 1'b1;
    repeat (4) tick();
    chk("rnd_idle", 64'(busy), 64'(0));

    // Long drain: timeout after DRAIN_MAX drain cycles, sequence still completes.
    pipe_empty = 1'b0;
    set_exp(5'd1, 32'h800, 32'h8000_0080);
    tick();
    commit_exp_ = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      chk("t5_timeout", 64'(drain_timeout), 64'(n >= 65));
      chk("t5_no_valid", 64'(redirect_valid), 64'(0));
      if (n < 70) tick();
    end
    pipe_empty = 1'b1;
    tick();
    chk("t5_valid", 64'(redirect_valid), 64'(1));
    chk("t5_rpc", 64'(redirect_pc), 64'(32'h8000_0080));
    tick();
    chk("t5_idle", 64'(busy), 64'(0));
    chk("t5_sticky", 64'(drain_timeout), 64'(1));
    tick();

    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
